// File: rtl/irq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : irq_pkg                                                    |
// | Description : Shared definitions for the interrupt sequencer: state      |
// |               encoding and the default vector-table placement, kept here |
// |               so the pipe buffer and the system register file use the    |
// |               same handler addresses.                                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package irq_pkg;

  // Sequencer states, 2-bit explicit encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ISR  = 2'd2,
    RET  = 2'd3
  } irq_state_e;

  // Width of the serviced-source id (covers up to 16 sources).
  localparam int IRQ_ID_W = 4;

  // Vector for source 0 and log2 of the vector stride in bytes.
  localparam logic [31:0] IRQ_IHA_BASE_DEFAULT  = 32'h0000_0040;
  localparam int          IRQ_VEC_SHIFT_DEFAULT = 4;

endpackage : irq_pkg
`default_nettype wire

// File: rtl/irq_prio_sel.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : irq_prio_sel                                               |
// | Description : Combinational winner select over the eligible request set. |
// |               Default build: fixed priority, lowest index wins.          |
// |               With IRQ_SEQ_RR_PRIO_EN defined: round-robin, the search   |
// |               starts at ptr+1 and wraps modulo NUM_SRC.                  |
// | Ports       : elig   - eligible requests (pending & mask)                |
// |               ptr    - last-served source (ignored in fixed mode)        |
// |               winner - selected source id, zero-extended                 |
// |               valid  - at least one eligible request                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module irq_prio_sel
  import irq_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0]  elig,
  input  logic [IRQ_ID_W-1:0] ptr,
  output logic [IRQ_ID_W-1:0] winner,
  output logic                valid
);

  assign valid = |elig;

`ifdef IRQ_SEQ_RR_PRIO_EN
  // Rank every eligible source by its distance from ptr+1 (mod NUM_SRC) and
  // keep the nearest one. The 2*NUM_SRC bias keeps the dividend positive.
  int dist;
  int best;

  always_comb begin
    winner = '0;
    dist   = 0;
    best   = NUM_SRC;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (elig[i]) begin
        dist = (i + 2 * NUM_SRC - int'(ptr) - 1) % NUM_SRC;
        if (dist < best) begin
          best   = dist;
          winner = IRQ_ID_W'(i);
        end
      end
    end
  end
`else
  // The pointer only matters for round-robin; fold it into a sink here.
  logic w_ptr_unused;
  assign w_ptr_unused = ^ptr;

  // Scan high to low so the lowest set index is written last.
  always_comb begin
    winner = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (elig[i]) begin
        winner = IRQ_ID_W'(i);
      end
    end
  end
`endif

endmodule : irq_prio_sel
`default_nettype wire

// File: rtl/irq_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : irq_sequencer                                              |
// | Description : Interrupt controller for the pipe buffer IRQ / return path.|
// |               Captures rising edges on NUM_SRC lines into pending,       |
// |               masks them, grants one source, drives IRQ/IHA/IRA and      |
// |               tracks the (non-nested) handler until sysRetIn.            |
// | Ports       : clk, rst (sync, active-low)                                |
// |               irqSrc   - raw interrupt lines, rising edge requests       |
// |               maskWrEn / maskIn - mask register write (1 = enabled)      |
// |               pcIn     - resume PC, latched into IRA on grant            |
// |               flushIn  - pipe buffer flush (blocks grant / acks IRQ)     |
// |               sysRetIn - system return from the handler                  |
// |               IRQ, IHA, IRA, irqId, inIsr, pending - registered outputs  |
// | Options     : IRQ_SEQ_RR_PRIO_EN - round-robin selection with a          |
// |               last-served pointer; undefined = fixed lowest-index        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module irq_sequencer
  import irq_pkg::*;
#(
  parameter int                   NUM_SRC   = 4,
  parameter int                   BIT_WIDTH = 32,
  parameter logic [BIT_WIDTH-1:0] IHA_BASE  = BIT_WIDTH'(IRQ_IHA_BASE_DEFAULT),
  parameter int                   VEC_SHIFT = IRQ_VEC_SHIFT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_SRC-1:0]   irqSrc,
  input  logic                 maskWrEn,
  input  logic [NUM_SRC-1:0]   maskIn,
  input  logic [BIT_WIDTH-1:0] pcIn,
  input  logic                 flushIn,
  input  logic                 sysRetIn,
  output logic                 IRQ,
  output logic [BIT_WIDTH-1:0] IHA,
  output logic [BIT_WIDTH-1:0] IRA,
  output logic [IRQ_ID_W-1:0]  irqId,
  output logic                 inIsr,
  output logic [NUM_SRC-1:0]   pending
);

  irq_state_e             state_q, state_d;
  logic [NUM_SRC-1:0]     src_prev_q;
  logic [NUM_SRC-1:0]     pending_q, pending_d;
  logic [NUM_SRC-1:0]     mask_q, mask_d;
  logic                   irq_q, irq_d;
  logic                   in_isr_q, in_isr_d;
  logic [BIT_WIDTH-1:0]   iha_q, iha_d;
  logic [BIT_WIDTH-1:0]   ira_q, ira_d;
  logic [IRQ_ID_W-1:0]    irq_id_q, irq_id_d;

  logic [NUM_SRC-1:0]     w_edge;
  logic [NUM_SRC-1:0]     w_elig;
  logic [NUM_SRC-1:0]     w_clr;
  logic [IRQ_ID_W-1:0]    w_winner;
  logic [IRQ_ID_W-1:0]    w_ptr;
  logic                   w_valid;
  logic                   w_ack;
  logic [BIT_WIDTH-1:0]   w_iha_grant;

  assign w_edge = irqSrc & ~src_prev_q;
  assign w_elig = pending_q & mask_q;
  assign mask_d = maskWrEn ? maskIn : mask_q;

  // Vector address; overflow past BIT_WIDTH is intentionally dropped.
  assign w_iha_grant = IHA_BASE + (BIT_WIDTH'(w_winner) << VEC_SHIFT);

  // Acknowledge clears the serviced bit, but a fresh edge on the same cycle
  // re-arms it so that request is not lost.
  assign w_clr     = w_ack ? (NUM_SRC'(1) << irq_id_q) : '0;
  assign pending_d = (pending_q & ~w_clr) | w_edge;

  irq_prio_sel #(
    .NUM_SRC (NUM_SRC)
  ) u_prio_sel (
    .elig   (w_elig),
    .ptr    (w_ptr),
    .winner (w_winner),
    .valid  (w_valid)
  );

`ifdef IRQ_SEQ_RR_PRIO_EN
  // Last-served pointer; resets to NUM_SRC-1 so source 0 is searched first.
  logic [IRQ_ID_W-1:0] ptr_q, ptr_d;

  assign ptr_d = w_ack ? irq_id_q : ptr_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q <= IRQ_ID_W'(NUM_SRC - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign w_ptr = ptr_q;
`else
  assign w_ptr = IRQ_ID_W'(NUM_SRC - 1);
`endif

  // Next-state and output logic.
  always_comb begin
    state_d  = state_q;
    irq_d    = 1'b0;
    in_isr_d = in_isr_q;
    iha_d    = iha_q;
    ira_d    = ira_q;
    irq_id_d = irq_id_q;
    w_ack    = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_isr_d = 1'b0;
        // A flush means pcIn is not a valid resume point; hold off the grant.
        if (w_valid && !flushIn) begin
          state_d  = REQ;
          irq_id_d = w_winner;
          ira_d    = pcIn;
          iha_d    = w_iha_grant;
        end
      end
      REQ: begin
        // IRQ is asserted from the cycle after the grant; the pipe buffer
        // answers with a flush, which acknowledges the request.
        if (flushIn) begin
          w_ack    = 1'b1;
          in_isr_d = 1'b1;
          state_d  = ISR;
        end else begin
          irq_d = 1'b1;
        end
      end
      ISR: begin
        in_isr_d = 1'b1;
        if (sysRetIn) begin
          in_isr_d = 1'b0;
          state_d  = RET;
        end
      end
      RET: begin
        // Guard cycle so the pipe buffer can flush after the return.
        in_isr_d = 1'b0;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      src_prev_q <= '0;
      pending_q  <= '0;
      mask_q     <= '0;
      irq_q      <= 1'b0;
      in_isr_q   <= 1'b0;
      iha_q      <= '0;
      ira_q      <= '0;
      irq_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      src_prev_q <= irqSrc;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      irq_q      <= irq_d;
      in_isr_q   <= in_isr_d;
      iha_q      <= iha_d;
      ira_q      <= ira_d;
      irq_id_q   <= irq_id_d;
    end
  end

  assign IRQ     = irq_q;
  assign IHA     = iha_q;
  assign IRA     = ira_q;
  assign irqId   = irq_id_q;
  assign inIsr   = in_isr_q;
  assign pending = pending_q;

endmodule : irq_sequencer
`default_nettype wire

// File: doc/irq_sequencer.md
Name: irq_sequencer

Overview:
- Interrupt controller that sequences the pipeline buffer's IRQ / interrupt-return path.
- Captures edges on NUM_SRC external interrupt lines and masks them. Selects one source and drives IRQ, the handler address IHA and the return address IRA into the pipe buffer.
- Tracks the in-handler state until the pipe buffer reports a system return (sysRetIn). No nesting.

Parameters:
- NUM_SRC, 4, number of interrupt sources (2..16).
- BIT_WIDTH, 32, address width.
- IHA_BASE, 32'h00000040, address of the vector for source 0.
- VEC_SHIFT, 4, log2 of the vector stride in bytes.

Ports:
- clk  in  1  clock, all logic on posedge
- rst  in  1  synchronous, active-low reset
- irqSrc  in  NUM_SRC  raw interrupt lines; rising edge requests service
- maskWrEn  in  1  write enable for the mask register
- maskIn  in  NUM_SRC  new mask value; 1 = enabled
- pcIn  in  BIT_WIDTH  PC of the next instruction to resume; sampled on grant
- flushIn  in  1  flush output of the pipe buffer
- sysRetIn  in  1  system-return indication from the pipe buffer
- IRQ  out  1  interrupt request to the pipe buffer
- IHA  out  BIT_WIDTH  interrupt handler address
- IRA  out  BIT_WIDTH  interrupt return address
- irqId  out  4  id of the source being serviced
- inIsr  out  1  high while a handler is active
- pending  out  NUM_SRC  captured, not-yet-serviced requests

Behaviour:
- Reset (rst==0 at posedge): state=IDLE; IRQ, inIsr, IHA, IRA, irqId, pending, mask and irqSrc history all 0.
  - Reset mid-REQ or mid-ISR aborts immediately. No IRQ pulse survives reset.
- Edge capture: pending[i] sets when irqSrc[i]==1 and the previous-cycle sample ==0.
  - pending[i] clears on grant acknowledge (REQ->ISR).
  - Set and clear in the same cycle: set wins, so the bit stays pending.
- Mask: maskWrEn loads maskIn at posedge, visible to selection in the next cycle. The mask does not affect capture.
- Eligible set: elig = pending & mask.
- Selection: fixed priority, lowest index wins.
- States:
  - IDLE:
    - If elig!=0 and flushIn==0: latch irqId=winner, IRA=pcIn, IHA=IHA_BASE + (winner << VEC_SHIFT); go to REQ.
    - The sum is truncated to BIT_WIDTH.
    - flushIn==1 blocks a grant that cycle, because the PC in flight is invalid.
  - REQ:
    - IRQ=1, registered, so it is first seen one cycle after the grant decision.
    - Hold until flushIn==1 is sampled. On that cycle: clear pending[irqId], set inIsr=1, drop IRQ, go to ISR.
    - Masking the source while in REQ does not cancel the grant.
  - ISR:
    - inIsr=1; IHA, IRA and irqId are held.
    - New edges still capture into pending.
    - sysRetIn==1 -> go to RET.
  - RET: one guard cycle with inIsr=0 and no grant (lets the pipe buffer flush after the return); then IDLE.
- sysRetIn in IDLE or REQ is ignored.
- Latency: from the irqSrc edge, pending sets 1 cycle later, the grant decision comes in the next cycle, and IRQ is high 1 cycle after that (3 cycles total).
- Outputs are all registered.
- irqId is zero-extended to 4 bits.

Optional Feature:
- Macro: IRQ_SEQ_RR_PRIO_EN.
- Defined: round-robin selection.
  - A last-served pointer updates on each REQ->ISR transition.
  - Search starts at pointer+1, wrapping modulo NUM_SRC.
  - The pointer resets to NUM_SRC-1, so the first grant favours source 0.
- Undefined: fixed lowest-index priority; no pointer register.

Decomposition:
- Shared package irq_pkg:
  - State encoding constants (IDLE=2'd0, REQ=2'd1, ISR=2'd2, RET=2'd3).
  - Default IHA_BASE and VEC_SHIFT constants, so the pipe buffer and the system register file agree on them.
- One sub-module, irq_prio_sel: combinational winner select from (elig, pointer), producing winner and valid. The RR variant sits inside it under the macro.

Test Plan:
- Basic service:
  - Stimulus: mask=4'b1111; pulse irqSrc[2]; pcIn=32'h100; return flushIn=1 two cycles after IRQ rises.
  - Required: IRQ rises 3 cycles after the edge; IHA=32'h60, IRA=32'h100, irqId=2; inIsr=1 after the flush; pending[2]=0.
- Fixed priority:
  - Stimulus: edges on src1 and src3 in the same cycle.
  - Required: src1 serviced first (IHA=32'h50). After sysRetIn plus the RET cycle, src3 is granted (IHA=32'h70).
- Mask and flush gating:
  - Stimulus: mask=0 with src0 edge. Then set mask=1 while holding flushIn=1 for 2 cycles.
  - Required: no IRQ while masked or while flushIn=1. Grant follows the first cycle with flushIn=0.
- Re-pend during clear:
  - Stimulus: src0 edge in the same cycle as its REQ->ISR acknowledge.
  - Required: pending[0] stays 1; src0 serviced again after the return.
- Reset mid-ISR:
  - Stimulus: rst=0 for one cycle while inIsr=1.
  - Required: all outputs 0 and state IDLE the next cycle; a later sysRetIn causes nothing.
- Round-robin (macro on):
  - Stimulus: src0 and src1 held re-pending continuously.
  - Required: grants alternate 0, 1, 0, 1.
